// File: rtl/mul_div_unit_if.sv
// ---------------------------------------------------------------------------
// mul_div_unit_if
//   Request/response bundle between the EX-stage operand selection and the
//   iterative multiply/divide unit.
//
//   master (EX stage) drives : start, op, busa, busb, cancel
//   slave  (mul_div_unit)    : busy, done, hi, lo
//
//   start   request, sampled by the unit only while busy=0
//   op      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no action
//   busa    operand A (rs / dividend), also MTHI/MTLO write data
//   busb    operand B (rt / divisor)
//   cancel  flush from exception/branch, aborts an in-flight operation
//   busy    operation in flight, EX stalls while high
//   done    one-cycle pulse, hi/lo hold the new result
//   hi, lo  architectural HI/LO registers
// ---------------------------------------------------------------------------
interface mul_div_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] busa;
  logic [DATA_W-1:0] busb;
  logic              cancel;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, busa, busb, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, busa, busb, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Iterative multiply/divide unit with HI/LO registers for the EX stage.
//   MULT/MULTU use shift-add, DIV/DIVU use restoring division, both one bit
//   per cycle over DATA_W cycles (state CALC) followed by a one-cycle sign
//   correction (state FIX). MTHI/MTLO write HI/LO directly in the request
//   cycle.
//
// Ports
//   clk   in  clock, all state updates on the rising edge
//   rst   in  synchronous reset, active-high
//   mdu   mul_div_unit_if.slave  (start/op/busa/busb/cancel in,
//                                  busy/done/hi/lo out)
//
// Parameters
//   DATA_W  operand and HI/LO width
//   CNT_W   iteration counter width, must be able to hold DATA_W
//
// Configuration
//   MDU_FAST_MUL_EN  when defined, MULT/MULTU use a single-cycle
//                    combinational multiplier: hi/lo are written at the end
//                    of the request cycle, done pulses the next cycle and
//                    busy stays low. Division is unaffected.
// ---------------------------------------------------------------------------
module mul_div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave mdu
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  // Two's-complement magnitude; the most negative value maps onto itself,
  // which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                 input logic            neg);
    return neg ? (~v) + DATA_W'(1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
    return (~v) + DATA_W'(1);
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v);
    return (~v) + (2*DATA_W)'(1);
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                busy;

  // Latched operation context (data, not reset)
  logic                is_div_q, sa_q, sb_q, dz_q;
  logic [DATA_W-1:0]   opnd_q;   // multiplicand for mul, divisor for div
  logic [DATA_W-1:0]   a_raw_q;  // busa as latched, for divide-by-zero HI
  logic [2*DATA_W-1:0] acc_q;    // mul: {partial, multiplier}  div: {rem, quo}
  logic [2*DATA_W-1:0] acc_step;

  logic [DATA_W-1:0]   hi_q, lo_q, hi_d, lo_d;
  logic                hi_we, lo_we;

  logic                accept, op_mul, op_div, op_signed;
  logic                sgn_a, sgn_b, go_iter, go_fast;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [2*DATA_W-1:0] fast_res;

  // ---- request decode (cycle T) ----
  always_comb begin
    accept    = mdu.start & ~busy & ~mdu.cancel;
    op_mul    = (mdu.op == OP_MULT) | (mdu.op == OP_MULTU);
    op_div    = (mdu.op == OP_DIV)  | (mdu.op == OP_DIVU);
    op_signed = (mdu.op == OP_MULT) | (mdu.op == OP_DIV);
    sgn_a     = op_signed & mdu.busa[DATA_W-1];
    sgn_b     = op_signed & mdu.busb[DATA_W-1];
    a_mag     = abs_val(mdu.busa, sgn_a);
    b_mag     = abs_val(mdu.busb, sgn_b);
    go_fast   = accept & op_mul & FAST_MUL;
    go_iter   = accept & (op_div | (op_mul & ~FAST_MUL));
  end

`ifdef MDU_FAST_MUL_EN
  always_comb begin
    fast_res = (2*DATA_W)'(a_mag) * (2*DATA_W)'(b_mag);
    if (sgn_a ^ sgn_b) fast_res = neg_2w(fast_res);
  end
`else
  assign fast_res = '0;
`endif

  // ---- CALC: one multiplier/quotient bit per cycle ----
  logic [DATA_W:0] mul_sum, div_shift, div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Remainder shifted left with the next dividend bit; a clear borrow
    // (div_diff MSB) means the divisor fits and the quotient bit is 1.
    div_shift = acc_q[2*DATA_W-1:DATA_W-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      acc_step = {(div_diff[DATA_W] ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0]),
                  acc_q[DATA_W-2:0], ~div_diff[DATA_W]};
    end else begin
      acc_step = {mul_sum, acc_q[DATA_W-1:1]};
    end
  end

  // ---- FIX: sign correction and special cases ----
  logic [2*DATA_W-1:0] mul_res;
  logic [DATA_W-1:0]   quo, rem, fix_hi, fix_lo;

  always_comb begin
    mul_res = (sa_q ^ sb_q) ? neg_2w(acc_q) : acc_q;
    quo     = (sa_q ^ sb_q) ? neg_w(acc_q[DATA_W-1:0]) : acc_q[DATA_W-1:0];
    rem     = sa_q ? neg_w(acc_q[2*DATA_W-1:DATA_W]) : acc_q[2*DATA_W-1:DATA_W];
    fix_hi  = rem;
    fix_lo  = quo;
    if (!is_div_q) begin
      fix_hi = mul_res[2*DATA_W-1:DATA_W];
      fix_lo = mul_res[DATA_W-1:0];
    end else if (dz_q) begin
      fix_hi = a_raw_q;
      fix_lo = '1;
    end
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: if (go_iter) state_d = S_CALC;
      S_CALC: begin
        if (mdu.cancel) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- FSM: outputs and HI/LO write control ----
  always_comb begin
    busy   = (state_q != S_IDLE);
    done_d = 1'b0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    hi_d   = fix_hi;
    lo_d   = fix_lo;
    if (state_q == S_FIX && !mdu.cancel) begin
      hi_we  = 1'b1;
      lo_we  = 1'b1;
      done_d = 1'b1;
    end else if (go_fast) begin
      hi_we  = 1'b1;
      lo_we  = 1'b1;
      hi_d   = fast_res[2*DATA_W-1:DATA_W];
      lo_d   = fast_res[DATA_W-1:0];
      done_d = 1'b1;
    end else if (accept && mdu.op == OP_MTHI) begin
      hi_we  = 1'b1;
      hi_d   = mdu.busa;
    end else if (accept && mdu.op == OP_MTLO) begin
      lo_we  = 1'b1;
      lo_d   = mdu.busa;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
    end
  end

  // Operand/accumulator registers carry no reset: they are reloaded on
  // every accepted mul/div and never reach hi/lo without passing FIX.
  always_ff @(posedge clk) begin
    if (go_iter) begin
      is_div_q <= op_div;
      sa_q     <= sgn_a;
      sb_q     <= sgn_b;
      dz_q     <= (mdu.busb == '0);
      a_raw_q  <= mdu.busa;
      opnd_q   <= op_div ? b_mag : a_mag;
      acc_q    <= {{DATA_W{1'b0}}, (op_div ? a_mag : b_mag)};
    end else if (state_q == S_CALC) begin
      acc_q    <= acc_step;
    end
  end

  assign mdu.busy = busy;
  assign mdu.done = done_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] exp_hi, exp_lo;

  mul_div_unit_if #(.DATA_W(32)) mdu_if ();

  mul_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (mdu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operands.
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, b,
                                 output logic [31:0] rh, rl);
    longint x, y, p, q, r;
    if (op == 3'd0 || op == 3'd2) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    rh = '0; rl = '0; p = 0; q = 0; r = 0;
    if (op <= 3'd1) begin
      p = x * y;
      rh = p[63:32];
      rl = p[31:0];
    end else if (b == 32'd0) begin
      rl = '1;
      rh = a;
    end else begin
      q = x / y;
      r = x % y;
      rl = q[31:0];
      rh = r[31:0];
    end
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    return (FAST && op <= 3'd1) ? 1 : 34;
  endfunction

  task automatic do_muldiv(input logic [2:0] op, input logic [31:0] a, b,
                           input logic [31:0] eh, el, input string name);
    int busy_cnt, done_at, lat;
    lat = lat_of(op);
    mdu_if.start = 1'b1; mdu_if.op = op; mdu_if.busa = a; mdu_if.busb = b;
    tick();
    mdu_if.start = 1'b0;
    busy_cnt = 0; done_at = 0;
    for (int k = 1; k <= 60; k++) begin
      if (mdu_if.done === 1'b1) begin done_at = k; break; end
      if (mdu_if.busy === 1'b1) busy_cnt++;
      tick();
    end
    checks++;
    if (done_at !== lat) begin failures++; $display("FAIL %s latency: got %0d expected %0d", name, done_at, lat); end
    checks++;
    if (busy_cnt !== lat - 1) begin failures++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, lat - 1); end
    checks++;
    if (mdu_if.busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_done: got %b expected 0", name, mdu_if.busy); end
    checks++;
    if (mdu_if.hi !== eh || mdu_if.lo !== el) begin
      failures++;
      $display("FAIL %s result: op=%0d a=%h b=%h hi=%h lo=%h expected hi=%h lo=%h", name, op, a, b, mdu_if.hi, mdu_if.lo, eh, el);
    end
    exp_hi = eh; exp_lo = el;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mdu_if.start = 1'b0; mdu_if.op = '0; mdu_if.busa = '0; mdu_if.busb = '0; mdu_if.cancel = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if (mdu_if.busy !== 1'b0 || mdu_if.done !== 1'b0 || mdu_if.hi !== 32'd0 || mdu_if.lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", mdu_if.busy, mdu_if.done, mdu_if.hi, mdu_if.lo);
    end
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_mthi_mtlo();
    mdu_if.start = 1'b1; mdu_if.op = 3'd4; mdu_if.busa = 32'h1234_5678;
    tick();
    checks++;
    if (mdu_if.hi !== 32'h1234_5678 || mdu_if.lo !== exp_lo || mdu_if.busy !== 1'b0 || mdu_if.done !== 1'b0) begin
      failures++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b expected %h %h 0 0", mdu_if.hi, mdu_if.lo, mdu_if.busy, mdu_if.done, 32'h1234_5678, exp_lo);
    end
    mdu_if.op = 3'd5; mdu_if.busa = 32'h9ABC_DEF0;
    tick();
    mdu_if.start = 1'b0;
    checks++;
    if (mdu_if.lo !== 32'h9ABC_DEF0 || mdu_if.hi !== 32'h1234_5678 || mdu_if.busy !== 1'b0 || mdu_if.done !== 1'b0) begin
      failures++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b expected 12345678 9abcdef0 0 0", mdu_if.hi, mdu_if.lo, mdu_if.busy, mdu_if.done);
    end
    exp_hi = 32'h1234_5678; exp_lo = 32'h9ABC_DEF0;
    tick();
    checks++;
    if (mdu_if.done !== 1'b0) begin failures++; $display("FAIL mt_no_done: done=%b expected 0", mdu_if.done); end
  endtask

  task automatic test_directed();
    do_muldiv(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    do_muldiv(3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
    do_muldiv(3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    do_muldiv(3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, "divu_by_zero");
    do_muldiv(3'd2, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, "div_by_zero_neg");
    do_muldiv(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_overflow");
    do_muldiv(3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_pos_neg");
  endtask

  task automatic test_cancel();
    int dn;
    mdu_if.start = 1'b1; mdu_if.op = 3'd4; mdu_if.busa = 32'hA5A5_0001;
    tick();
    mdu_if.op = 3'd5; mdu_if.busa = 32'h5A5A_0002;
    tick();
    exp_hi = 32'hA5A5_0001; exp_lo = 32'h5A5A_0002;
    mdu_if.op = 3'd3; mdu_if.busa = 32'd1000; mdu_if.busb = 32'd7;
    tick();                          // T+1
    mdu_if.start = 1'b0;
    repeat (4) tick();               // T+5
    mdu_if.start = 1'b1; mdu_if.op = 3'd1; mdu_if.busa = 32'd3; mdu_if.busb = 32'd5;
    tick();                          // T+6
    mdu_if.start = 1'b0;
    checks++;
    if (mdu_if.busy !== 1'b1) begin failures++; $display("FAIL cancel_busy_mid: busy=%b expected 1", mdu_if.busy); end
    repeat (4) tick();               // T+10
    mdu_if.cancel = 1'b1;
    tick();                          // T+11
    mdu_if.cancel = 1'b0;
    checks++;
    if (mdu_if.busy !== 1'b0 || mdu_if.done !== 1'b0) begin
      failures++; $display("FAIL cancel_busy_drop: busy=%b done=%b expected 0 0", mdu_if.busy, mdu_if.done);
    end
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      if (mdu_if.done !== 1'b0 || mdu_if.busy !== 1'b0) dn++;
      tick();
    end
    checks++;
    if (dn !== 0) begin failures++; $display("FAIL cancel_quiet: active_cycles=%0d expected 0", dn); end
    checks++;
    if (mdu_if.hi !== exp_hi || mdu_if.lo !== exp_lo) begin
      failures++; $display("FAIL cancel_hilo: hi=%h lo=%h expected %h %h", mdu_if.hi, mdu_if.lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_cancel_idle();
    mdu_if.cancel = 1'b1; mdu_if.start = 1'b1; mdu_if.op = 3'd4; mdu_if.busa = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (mdu_if.hi !== exp_hi || mdu_if.busy !== 1'b0) begin
      failures++; $display("FAIL cancel_idle_mthi: hi=%h busy=%b expected %h 0", mdu_if.hi, mdu_if.busy, exp_hi);
    end
    mdu_if.op = 3'd2; mdu_if.busa = 32'd50; mdu_if.busb = 32'd3;
    tick();
    mdu_if.cancel = 1'b0; mdu_if.start = 1'b0;
    checks++;
    if (mdu_if.busy !== 1'b0 || mdu_if.lo !== exp_lo) begin
      failures++; $display("FAIL cancel_idle_div: busy=%b lo=%h expected 0 %h", mdu_if.busy, mdu_if.lo, exp_lo);
    end
  endtask

  task automatic test_op67();
    int act;
    act = 0;
    mdu_if.start = 1'b1; mdu_if.op = 3'd6; mdu_if.busa = 32'h1111_1111; mdu_if.busb = 32'h2;
    tick();
    if (mdu_if.busy !== 1'b0 || mdu_if.done !== 1'b0) act++;
    mdu_if.op = 3'd7;
    tick();
    mdu_if.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (mdu_if.busy !== 1'b0 || mdu_if.done !== 1'b0) act++;
      tick();
    end
    checks++;
    if (act !== 0) begin failures++; $display("FAIL op67_idle: active_cycles=%0d expected 0", act); end
    checks++;
    if (mdu_if.hi !== exp_hi || mdu_if.lo !== exp_lo) begin
      failures++; $display("FAIL op67_hilo: hi=%h lo=%h expected %h %h", mdu_if.hi, mdu_if.lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_cancel_done();
    do_muldiv(3'd3, 32'd1000, 32'd7, 32'd6, 32'd142, "divu_1000_7");
    mdu_if.cancel = 1'b1;
    #1;
    checks++;
    if (mdu_if.done !== 1'b1) begin failures++; $display("FAIL cancel_done_pulse: done=%b expected 1", mdu_if.done); end
    tick();
    mdu_if.cancel = 1'b0;
    checks++;
    if (mdu_if.hi !== 32'd6 || mdu_if.lo !== 32'd142 || mdu_if.done !== 1'b0 || mdu_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL cancel_done_commit: hi=%h lo=%h done=%b busy=%b expected 6 8e 0 0", mdu_if.hi, mdu_if.lo, mdu_if.done, mdu_if.busy);
    end
  endtask

  // Each op is issued in the done cycle of the previous one.
  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] a, b, rh, rl;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      ref_md(op, a, b, rh, rl);
      do_muldiv(op, a, b, rh, rl, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_rst_mid();
    int dn;
    mdu_if.start = 1'b1; mdu_if.op = 3'd3; mdu_if.busa = 32'd1000; mdu_if.busb = 32'd7;
    tick();
    mdu_if.start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (mdu_if.busy !== 1'b0 || mdu_if.done !== 1'b0 || mdu_if.hi !== 32'd0 || mdu_if.lo !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", mdu_if.busy, mdu_if.done, mdu_if.hi, mdu_if.lo);
    end
    exp_hi = '0; exp_lo = '0;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      if (mdu_if.done !== 1'b0) dn++;
      tick();
    end
    checks++;
    if (dn !== 0) begin failures++; $display("FAIL rst_mid_no_done: done_cycles=%0d expected 0", dn); end
    do_muldiv(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, "after_rst");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    mdu_if.start = 1'b0;
    mdu_if.cancel = 1'b0;
    mdu_if.op = '0;
    mdu_if.busa = '0;
    mdu_if.busb = '0;
    test_reset();
    test_mthi_mtlo();
    test_directed();
    test_cancel();
    test_cancel_idle();
    test_op67();
    test_cancel_done();
    test_back_to_back();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
